ballot_unit: RTL and testbench
==============================

# ballot_unit

Upstream input stage of the EVM voting FSM. It takes three raw, bouncy, active-low candidate pushbuttons and synchronises and debounces them. It enforces one vote per ballot, where each ballot is issued by the presiding officer's `ballot_issue` pulse. For every accepted vote it drives exactly one clean active-low pulse on `cand1`/`cand2`/`cand3`, which the vote counter's falling-edge detection consumes.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised cycles required before a debounced level changes (≥2).
- `VOTE_PULSE_CYCLES`, default 4: cycles a `candN` output is held low per accepted vote (≥2).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `btn1_n`, `btn2_n`, `btn3_n`  in  1 each: raw asynchronous candidate buttons, active-low (0 = pressed).
- `ballot_issue`  in  1: one-cycle pulse authorising exactly one vote.
- `voting_over`  in  1: level; session closed, no further ballots.
- `cand1`, `cand2`, `cand3`  out  1 each: registered, active-low, idle high; at most one low at any time.
- `ballot_ready`  out  1: high while a ballot is armed (state ARMED); drives the voter LED.
- `vote_ack`  out  1: one-cycle pulse when an accepted vote's pulse completes; drives the beeper.
- `invalid_press`  out  1: one-cycle pulse on a rejected multi-button press.

## Operation
- Per button: 2-flop synchroniser, with flops reset to 1. Then a debounce counter of width clog2(DEBOUNCE_CYCLES)+1.
  - While the synchronised level equals the debounced level, the counter is 0.
  - Otherwise the counter increments each cycle. On reaching DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - `pressed` = NOT debounced. `press_edge` = one-cycle pulse on a pressed 0→1 transition.
- FSM states: LOCKED, ARMED, EMIT, RELEASE. Reset state is LOCKED.
  - LOCKED: on `ballot_issue` && !`voting_over` → ARMED.
  - ARMED: on any `press_edge`, count the buttons currently pressed, including the new one.
    - Count = 1: latch that candidate index and go to EMIT.
    - Count > 1 (simultaneous edges, or a press while another is held): pulse `invalid_press` for 1 cycle and stay ARMED.
    - A button already held when ARMED is entered produces no edge, so it is ignored until it is released and re-pressed.
  - EMIT: the latched `candN` is low. A pulse counter runs for VOTE_PULSE_CYCLES cycles. Then `vote_ack` pulses and the FSM moves to RELEASE, or to LOCKED if `voting_over` is high.
  - RELEASE: wait until all three buttons are debounced-released, then → LOCKED.
- `voting_over` high:
  - ARMED → LOCKED next cycle; the ballot is discarded.
  - EMIT always completes its full pulse.
  - Forces LOCKED out of RELEASE.
- `ballot_issue` outside LOCKED is ignored; ballots do not queue. If it coincides with `voting_over`, `voting_over` wins and the FSM stays LOCKED.
- Reset values:
  - `cand1..3` = 1; `ballot_ready`, `vote_ack`, `invalid_press` = 0.
  - Debounced levels = 1 (released); all counters = 0; latched index cleared.
- A reset asserted mid-EMIT returns `candN` high on the next edge. The downstream counter may already have registered that vote; this is accepted.

## Timing
- Raw press (stable) to debounced press: 2 + DEBOUNCE_CYCLES edges.
- Debounced press edge to `candN` low: 1 edge. `candN` stays low for exactly VOTE_PULSE_CYCLES cycles.
- `vote_ack` is asserted in the cycle `candN` returns high.
- `ballot_issue` to `ballot_ready` high: 1 edge.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles never change the debounced level.
- Minimum spacing between accepted votes is ≥ VOTE_PULSE_CYCLES + 2 cycles, plus the release debounce time. The presiding officer's ballot rate must cover the downstream 16-cycle pause; this block does not enforce it.

## Structure
- Package `evm_pkg`:
  - FSM state typedef (2-bit: LOCKED, ARMED, EMIT, RELEASE).
  - `NUM_CAND` = 3.
  - Candidate index typedef (2-bit).
- Sub-module `button_debounce`: synchroniser, debounce counter, and `pressed`/`press_edge` generation; parameter DEBOUNCE_CYCLES; instantiated 3 times.
- The top level holds the FSM, pulse counter, candidate latch and output registers.

## Test plan
- Reset, then one clean press of `btn2_n` after `ballot_issue` → `cand2` low for exactly 4 cycles; `cand1`/`cand3` stay high; one `vote_ack`; `ballot_ready` 1→0.
- Press `btn1_n` with 5-cycle bounces for 40 cycles, then hold → exactly one `cand1` pulse; a second press without a new `ballot_issue` → no pulse.
- Press `btn1_n` and `btn3_n` in the same cycle → `invalid_press` pulses once, no `candN` pulse, still ARMED. Release both, press `btn3_n` → one `cand3` pulse.
- Hold `btn2_n` before `ballot_issue` → no pulse while held. Release then press → one `cand2` pulse.
- Raise `voting_over` during EMIT → the pulse still lasts 4 cycles, then LOCKED. Later `ballot_issue` pulses → `ballot_ready` stays 0.
- Assert `rst` in the 2nd EMIT cycle → next edge: all `candN` = 1, all other outputs 0, state LOCKED.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared types and helpers for the EVM ballot input stage.
// Candidate indices are 1-based so that zero can mean "no candidate latched".
package evm_pkg;

   localparam int NUM_CAND = 3;

   typedef enum logic [1:0] {
      LOCKED  = 2'd0,
      ARMED   = 2'd1,
      EMIT    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   typedef logic [1:0] cand_idx_t;

   localparam cand_idx_t CAND_NONE = 2'd0;

   function automatic logic [1:0] count_pressed(input logic [NUM_CAND-1:0] pressed);
      logic [1:0] total;
      total = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         total = total + {1'b0, pressed[i]};
      end
      return total;
   endfunction

   function automatic cand_idx_t first_pressed(input logic [NUM_CAND-1:0] pressed);
      cand_idx_t idx;
      idx = CAND_NONE;
      for (int i = NUM_CAND - 1; i >= 0; i--) begin
         if (pressed[i]) begin
            idx = cand_idx_t'(i + 1);
         end
      end
      return idx;
   endfunction

   function automatic logic [NUM_CAND-1:0] cand_onehot(input cand_idx_t idx);
      logic [NUM_CAND-1:0] vec;
      vec = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (idx == cand_idx_t'(i + 1)) begin
            vec[i] = 1'b1;
         end
      end
      return vec;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter-based debouncer for one active-low button.
// press_edge pulses for one cycle when the debounced level goes released -> pressed.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic pressed,
   output logic press_edge
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             deb_reg;
   logic             deb_prev_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   assign cnt_next = cnt_reg + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg    <= 1'b1;
         sync2_reg    <= 1'b1;
         deb_reg      <= 1'b1;
         deb_prev_reg <= 1'b1;
         cnt_reg      <= '0;
      end else begin
         sync1_reg    <= btn_n;
         sync2_reg    <= sync1_reg;
         deb_prev_reg <= deb_reg;
         if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
         end else if (cnt_next == CNT_DONE) begin
            // Level has disagreed for DEBOUNCE_CYCLES cycles: accept it.
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_next;
         end
      end
   end

   assign pressed    = ~deb_reg;
   assign press_edge = ~deb_reg & deb_prev_reg;

endmodule

// File: rtl/ballot_unit.sv
// One-vote-per-ballot front end: debounces three candidate buttons and emits
// a single fixed-length active-low pulse per accepted vote.
module ballot_unit
   import evm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int VOTE_PULSE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn1_n,
   input  logic btn2_n,
   input  logic btn3_n,
   input  logic ballot_issue,
   input  logic voting_over,
   output logic cand1,
   output logic cand2,
   output logic cand3,
   output logic ballot_ready,
   output logic vote_ack,
   output logic invalid_press
);

   localparam int                PCNT_W     = $clog2(VOTE_PULSE_CYCLES) + 1;
   localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(VOTE_PULSE_CYCLES - 1);

   logic [NUM_CAND-1:0] btn_n_vec;
   logic [NUM_CAND-1:0] pressed_vec;
   logic [NUM_CAND-1:0] edge_vec;
   logic [1:0]          press_count;
   cand_idx_t           press_idx;

   state_t              state_reg;
   cand_idx_t           cand_idx_reg;
   logic [PCNT_W-1:0]   pulse_cnt_reg;
   logic [NUM_CAND-1:0] cand_n_reg;
   logic                ballot_ready_reg;
   logic                vote_ack_reg;
   logic                invalid_press_reg;

   assign btn_n_vec = {btn3_n, btn2_n, btn1_n};

   generate
      for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .btn_n     (btn_n_vec[gi]),
            .pressed   (pressed_vec[gi]),
            .press_edge(edge_vec[gi])
         );
      end
   endgenerate

   // Count includes buttons already held, so a press during another hold is rejected.
   assign press_count = count_pressed(pressed_vec);
   assign press_idx   = first_pressed(pressed_vec);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= LOCKED;
         cand_idx_reg      <= CAND_NONE;
         pulse_cnt_reg     <= '0;
         cand_n_reg        <= '1;
         ballot_ready_reg  <= 1'b0;
         vote_ack_reg      <= 1'b0;
         invalid_press_reg <= 1'b0;
      end else begin
         vote_ack_reg      <= 1'b0;
         invalid_press_reg <= 1'b0;
         case (state_reg)
            LOCKED: begin
               if (ballot_issue && !voting_over) begin
                  state_reg        <= ARMED;
                  ballot_ready_reg <= 1'b1;
               end
            end
            ARMED: begin
               if (voting_over) begin
                  state_reg        <= LOCKED;
                  ballot_ready_reg <= 1'b0;
               end else if (|edge_vec) begin
                  if (press_count == 2'd1) begin
                     state_reg        <= EMIT;
                     ballot_ready_reg <= 1'b0;
                     cand_idx_reg     <= press_idx;
                     cand_n_reg       <= ~cand_onehot(press_idx);
                     pulse_cnt_reg    <= '0;
                  end else begin
                     invalid_press_reg <= 1'b1;
                  end
               end
            end
            EMIT: begin
               // The pulse always runs to full length, even once voting closes.
               if (pulse_cnt_reg == PULSE_LAST) begin
                  cand_n_reg    <= '1;
                  vote_ack_reg  <= 1'b1;
                  pulse_cnt_reg <= '0;
                  state_reg     <= voting_over ? LOCKED : RELEASE;
               end else begin
                  cand_n_reg    <= ~cand_onehot(cand_idx_reg);
                  pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
               end
            end
            RELEASE: begin
               if (voting_over || !(|pressed_vec)) begin
                  state_reg <= LOCKED;
               end
            end
            default: begin
               state_reg <= LOCKED;
            end
         endcase
      end
   end

   assign cand1         = cand_n_reg[0];
   assign cand2         = cand_n_reg[1];
   assign cand3         = cand_n_reg[2];
   assign ballot_ready  = ballot_ready_reg;
   assign vote_ack      = vote_ack_reg;
   assign invalid_press = invalid_press_reg;

endmodule

// File: tb/tb_ballot_unit.sv
// Scenario bench for ballot_unit: expected vote pulses are queued when a press is
// driven and matched by a monitor as each candN pulse completes.
module tb_ballot_unit;
   import evm_pkg::*;

   localparam int DEB   = 16;
   localparam int PULSE = 4;

   logic clk = 1'b0;
   logic rst;
   logic btn1_n, btn2_n, btn3_n;
   logic ballot_issue, voting_over;
   logic cand1, cand2, cand3;
   logic ballot_ready, vote_ack, invalid_press;

   always #5 clk = ~clk;

   ballot_unit #(
      .DEBOUNCE_CYCLES  (DEB),
      .VOTE_PULSE_CYCLES(PULSE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn1_n       (btn1_n),
      .btn2_n       (btn2_n),
      .btn3_n       (btn3_n),
      .ballot_issue (ballot_issue),
      .voting_over  (voting_over),
      .cand1        (cand1),
      .cand2        (cand2),
      .cand3        (cand3),
      .ballot_ready (ballot_ready),
      .vote_ack     (vote_ack),
      .invalid_press(invalid_press)
   );

   typedef struct {
      int idx;
      int len;
   } exp_pulse_t;

   exp_pulse_t exp_q[$];
   int n_checks    = 0;
   int n_fail      = 0;
   int pulses_seen = 0;
   int acks_seen   = 0;
   int inv_seen    = 0;
   int low_len[3]  = '{0, 0, 0};

   logic [2:0] mon_cv;
   int         mon_lows;
   int         mon_ended;
   exp_pulse_t mon_e;

   // Pulse monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      mon_cv    = {cand3, cand2, cand1};
      mon_lows  = 0;
      mon_ended = 0;
      for (int i = 0; i < 3; i++) begin
         if (mon_cv[i] === 1'b0) begin
            low_len[i]++;
            mon_lows++;
         end else if (low_len[i] > 0) begin
            if (rst !== 1'b1) begin
               mon_ended++;
               pulses_seen++;
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_pulse: cand%0d low for %0d cycles, required no pulse", i + 1, low_len[i]);
               end else begin
                  mon_e = exp_q.pop_front();
                  if ((i + 1) !== mon_e.idx || low_len[i] !== mon_e.len) begin
                     n_fail++;
                     $display("FAIL pulse_shape: got cand%0d low %0d cycles, required cand%0d low %0d cycles",
                              i + 1, low_len[i], mon_e.idx, mon_e.len);
                  end
               end
            end
            low_len[i] = 0;
         end
      end
      n_checks++;
      if (mon_lows > 1) begin
         n_fail++;
         $display("FAIL cand_onehot: %0d cand outputs low, required at most 1", mon_lows);
      end
      if (rst !== 1'b1) begin
         n_checks++;
         if (vote_ack !== (mon_ended != 0)) begin
            n_fail++;
            $display("FAIL vote_ack_timing: vote_ack=%b, required %b", vote_ack, (mon_ended != 0));
         end
      end
      if (vote_ack === 1'b1) acks_seen++;
      if (invalid_press === 1'b1) inv_seen++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue_ballot();
      ballot_issue = 1'b1;
      @(negedge clk);
      ballot_issue = 1'b0;
   endtask

   task automatic wait_pulses(input int target, input int budget, output bit done);
      int k;
      k = 0;
      while (pulses_seen < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      done = (pulses_seen >= target);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      n_checks++;
      if ({cand3, cand2, cand1} !== 3'b111) begin
         n_fail++; $display("FAIL reset_cand: got %b, required 111", {cand3, cand2, cand1});
      end
      n_checks++;
      if ({ballot_ready, vote_ack, invalid_press} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b, required 000", {ballot_ready, vote_ack, invalid_press});
      end
      n_checks++;
      if (dut.state_reg !== LOCKED) begin
         n_fail++; $display("FAIL reset_state: got %0d, required LOCKED", dut.state_reg);
      end
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_single_vote();
      int start, acks0;
      bit done;
      start = pulses_seen;
      acks0 = acks_seen;
      issue_ballot();
      n_checks++;
      if (ballot_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_ready: got %b, required 1", ballot_ready);
      end
      exp_q.push_back('{idx: 2, len: PULSE});
      btn2_n = 1'b0;
      wait_pulses(start + 1, 40, done);
      n_checks++;
      if (!done) begin
         n_fail++; $display("FAIL single_timeout: pulses %0d, required %0d", pulses_seen - start, 1);
      end
      n_checks++;
      if (ballot_ready !== 1'b0) begin
         n_fail++; $display("FAIL single_ready_drop: got %b, required 0", ballot_ready);
      end
      n_checks++;
      if (acks_seen - acks0 !== 1) begin
         n_fail++; $display("FAIL single_ack_count: got %0d, required 1", acks_seen - acks0);
      end
      n_checks++;
      if (dut.state_reg !== RELEASE) begin
         n_fail++; $display("FAIL single_release: got %0d, required RELEASE", dut.state_reg);
      end
      btn2_n = 1'b1;
      tick(25);
      n_checks++;
      if (dut.state_reg !== LOCKED) begin
         n_fail++; $display("FAIL single_relock: got %0d, required LOCKED", dut.state_reg);
      end
      $display("test_single_vote: pulses=%0d", pulses_seen - start);
   endtask

   task automatic test_bounce();
      int start;
      bit done;
      start = pulses_seen;
      issue_ballot();
      exp_q.push_back('{idx: 1, len: PULSE});
      for (int k = 0; k < 8; k++) begin
         btn1_n = (k % 2 == 0) ? 1'b0 : 1'b1;
         tick(5);
      end
      btn1_n = 1'b0;
      wait_pulses(start + 1, 40, done);
      n_checks++;
      if (!done) begin
         n_fail++; $display("FAIL bounce_timeout: pulses %0d, required 1", pulses_seen - start);
      end
      btn1_n = 1'b1;
      tick(25);
      btn1_n = 1'b0;
      tick(30);
      n_checks++;
      if (pulses_seen - start !== 1) begin
         n_fail++; $display("FAIL bounce_no_reballot: pulses %0d, required 1", pulses_seen - start);
      end
      n_checks++;
      if (ballot_ready !== 1'b0) begin
         n_fail++; $display("FAIL bounce_ready: got %b, required 0", ballot_ready);
      end
      btn1_n = 1'b1;
      tick(25);
      $display("test_bounce: pulses=%0d", pulses_seen - start);
   endtask

   task automatic test_multi_press();
      int start, inv0;
      bit done;
      start = pulses_seen;
      inv0  = inv_seen;
      issue_ballot();
      btn1_n = 1'b0;
      btn3_n = 1'b0;
      tick(25);
      n_checks++;
      if (inv_seen - inv0 !== 1) begin
         n_fail++; $display("FAIL multi_invalid: got %0d pulses, required 1", inv_seen - inv0);
      end
      n_checks++;
      if (pulses_seen !== start) begin
         n_fail++; $display("FAIL multi_no_vote: pulses %0d, required 0", pulses_seen - start);
      end
      n_checks++;
      if (ballot_ready !== 1'b1 || dut.state_reg !== ARMED) begin
         n_fail++; $display("FAIL multi_armed: ready=%b state=%0d, required ready=1 ARMED", ballot_ready, dut.state_reg);
      end
      btn1_n = 1'b1;
      btn3_n = 1'b1;
      tick(25);
      exp_q.push_back('{idx: 3, len: PULSE});
      btn3_n = 1'b0;
      wait_pulses(start + 1, 40, done);
      n_checks++;
      if (!done) begin
         n_fail++; $display("FAIL multi_retry_timeout: pulses %0d, required 1", pulses_seen - start);
      end
      btn3_n = 1'b1;
      tick(25);
      $display("test_multi_press: invalid=%0d pulses=%0d", inv_seen - inv0, pulses_seen - start);
   endtask

   task automatic test_held_before_issue();
      int start;
      bit done;
      start = pulses_seen;
      btn2_n = 1'b0;
      tick(25);
      issue_ballot();
      tick(30);
      n_checks++;
      if (pulses_seen !== start) begin
         n_fail++; $display("FAIL held_no_vote: pulses %0d, required 0", pulses_seen - start);
      end
      btn2_n = 1'b1;
      tick(25);
      n_checks++;
      if (ballot_ready !== 1'b1) begin
         n_fail++; $display("FAIL held_still_armed: got %b, required 1", ballot_ready);
      end
      exp_q.push_back('{idx: 2, len: PULSE});
      btn2_n = 1'b0;
      wait_pulses(start + 1, 40, done);
      n_checks++;
      if (!done) begin
         n_fail++; $display("FAIL held_repress_timeout: pulses %0d, required 1", pulses_seen - start);
      end
      btn2_n = 1'b1;
      tick(25);
      $display("test_held_before_issue: pulses=%0d", pulses_seen - start);
   endtask

   task automatic test_voting_over_emit();
      int start, k;
      bit done;
      start = pulses_seen;
      issue_ballot();
      exp_q.push_back('{idx: 1, len: PULSE});
      btn1_n = 1'b0;
      k = 0;
      while (cand1 !== 1'b0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (cand1 !== 1'b0) begin
         n_fail++; $display("FAIL over_emit_start: cand1=%b, required 0", cand1);
      end
      voting_over = 1'b1;
      wait_pulses(start + 1, 10, done);
      n_checks++;
      if (!done) begin
         n_fail++; $display("FAIL over_pulse_timeout: pulses %0d, required 1", pulses_seen - start);
      end
      n_checks++;
      if (dut.state_reg !== LOCKED) begin
         n_fail++; $display("FAIL over_locked: got %0d, required LOCKED", dut.state_reg);
      end
      for (int j = 0; j < 3; j++) begin
         issue_ballot();
         n_checks++;
         if (ballot_ready !== 1'b0) begin
            n_fail++; $display("FAIL over_no_ballot: ready=%b, required 0", ballot_ready);
         end
         tick(2);
      end
      btn1_n = 1'b1;
      tick(25);
      voting_over = 1'b0;
      tick(2);
      $display("test_voting_over_emit: pulses=%0d", pulses_seen - start);
   endtask

   task automatic test_reset_emit();
      int k;
      issue_ballot();
      btn3_n = 1'b0;
      k = 0;
      while (cand3 !== 1'b0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (cand3 !== 1'b0) begin
         n_fail++; $display("FAIL rst_emit_start: cand3=%b, required 0", cand3);
      end
      tick(1);
      rst = 1'b1;
      tick(1);
      n_checks++;
      if ({cand3, cand2, cand1} !== 3'b111) begin
         n_fail++; $display("FAIL rst_emit_cand: got %b, required 111", {cand3, cand2, cand1});
      end
      n_checks++;
      if ({ballot_ready, vote_ack, invalid_press} !== 3'b000) begin
         n_fail++; $display("FAIL rst_emit_flags: got %b, required 000", {ballot_ready, vote_ack, invalid_press});
      end
      n_checks++;
      if (dut.state_reg !== LOCKED) begin
         n_fail++; $display("FAIL rst_emit_state: got %0d, required LOCKED", dut.state_reg);
      end
      rst    = 1'b0;
      btn3_n = 1'b1;
      tick(25);
      $display("test_reset_emit: cand=%b", {cand3, cand2, cand1});
   endtask

   initial begin
      rst          = 1'b1;
      btn1_n       = 1'b1;
      btn2_n       = 1'b1;
      btn3_n       = 1'b1;
      ballot_issue = 1'b0;
      voting_over  = 1'b0;
      test_reset();
      test_single_vote();
      test_bounce();
      test_multi_press();
      test_held_before_issue();
      test_voting_over_emit();
      test_reset_emit();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL leftover_expected: %0d pulses still queued, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
